// File: rtl/fifo_drain_packer.sv
// Drains a show-ahead FIFO and packs `ratio` narrow items into one wide word on a
// valid/ready output register; a flush request emits a partial word with its item count.
module fifo_drain_packer #(
    parameter int unsigned width = 8,
    parameter int unsigned ratio = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    input  logic [width-1:0]             fifo_read_data,
    output logic                         fifo_pop,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [width*ratio-1:0]       out_data,
    output logic [$clog2(ratio+1)-1:0]   out_count
);

    localparam int unsigned CntW    = $clog2(ratio);
    localparam int unsigned OutCntW = $clog2(ratio + 1);
    localparam int unsigned WordW   = width * ratio;
    localparam logic [CntW-1:0] LastIdx = CntW'(ratio - 1);

    logic [CntW-1:0]    acc_cnt_q, acc_cnt_d;
    logic [WordW-1:0]   acc_data_q, acc_data_d;
    logic               flush_pend_q, flush_pend_d;
    logic               out_valid_q, out_valid_d;
    logic [WordW-1:0]   out_data_q, out_data_d;
    logic [OutCntW-1:0] out_count_q, out_count_d;

    logic               out_free;
    logic               acc_last;
    logic               pop;
    logic               fire;
    logic [WordW-1:0]   acc_word;

    // A slot being drained this cycle counts as free, hence the out_ready -> fifo_pop path.
    always_comb begin
        out_free = !out_valid_q || out_ready;
        acc_last = (acc_cnt_q == LastIdx);
        pop      = !fifo_empty && (!acc_last || out_free);
        fire     = flush_pend_q && !pop && (acc_cnt_q != '0) && out_free;
    end

    // Accumulator with the FIFO head merged into the current slice.
    always_comb begin
        acc_word = acc_data_q;
        for (int unsigned i = 0; i < ratio; i++) begin
            if (CntW'(i) == acc_cnt_q) begin
                acc_word[i*width +: width] = fifo_read_data;
            end
        end
    end

    always_comb begin
        acc_cnt_d    = acc_cnt_q;
        acc_data_d   = acc_data_q;
        flush_pend_d = flush_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;

        if (flush && ((acc_cnt_q != '0) || pop)) begin
            flush_pend_d = 1'b1;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (pop) begin
            if (acc_last) begin
                out_valid_d  = 1'b1;
                out_data_d   = acc_word;
                out_count_d  = OutCntW'(ratio);
                acc_cnt_d    = '0;
                acc_data_d   = '0;
                flush_pend_d = 1'b0;
            end else begin
                acc_cnt_d  = acc_cnt_q + CntW'(1);
                acc_data_d = acc_word;
            end
        end else if (fire) begin
            // Unused upper slices are already zero since the accumulator clears on every emit.
            out_valid_d  = 1'b1;
            out_data_d   = acc_data_q;
            out_count_d  = OutCntW'(acc_cnt_q);
            acc_cnt_d    = '0;
            acc_data_d   = '0;
            flush_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q    <= '0;
            acc_data_q   <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
        end else begin
            acc_cnt_q    <= acc_cnt_d;
            acc_data_q   <= acc_data_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
        end
    end

    assign fifo_pop  = pop;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(fifo_pop && fifo_empty));

    out_hold_until_ready: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_count)));

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Bench for fifo_drain_packer: directed scenarios plus random traffic against a
// queue-based reference model and an end-to-end item scoreboard.
module tb_fifo_drain_packer;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int CW = $clog2(R + 1);

    logic            clk;
    logic            rst;
    logic            fifo_empty;
    logic [W-1:0]    fifo_read_data;
    logic            fifo_pop;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [W*R-1:0]  out_data;
    logic [CW-1:0]   out_count;

    fifo_drain_packer #(
        .width (W),
        .ratio (R)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_pop       (fifo_pop),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO contents, reference model state and scoreboard.
    logic [W-1:0]   fq[$];
    logic [W-1:0]   m_acc[$];
    logic           m_valid;
    logic [W*R-1:0] m_data;
    int             m_count;
    logic           m_pend;
    logic [W-1:0]   sent[$];
    logic [W-1:0]   rcv[$];
    logic [W*R-1:0] words[$];
    int             npops;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [W*R-1:0] pack_acc();
        logic [W*R-1:0] d = '0;
        foreach (m_acc[i]) d[i*W +: W] = m_acc[i];
        return d;
    endfunction

    task automatic model_load();
        m_data  = pack_acc();
        m_count = m_acc.size();
        m_valid = 1'b1;
        m_acc.delete();
        m_pend  = 1'b0;
    endtask

    task automatic model_reset();
        m_acc.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_count = 0;
        m_pend  = 1'b0;
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic step();
        logic exp_pop, free, fire;
        logic [W*R-1:0] d;
        fifo_empty     = (fq.size() == 0);
        fifo_read_data = fifo_empty ? '0 : fq[0];
        #1;
        free    = !m_valid || out_ready;
        exp_pop = !fifo_empty && ((m_acc.size() < R - 1) || free);
        check_eq("pop", 64'(fifo_pop), 64'(exp_pop));
        check_eq("valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("data", 64'(out_data), 64'(m_data));
            check_eq("count", 64'(out_count), 64'(m_count));
        end
        if (out_valid && out_ready) begin
            d = out_data;
            words.push_back(d);
            for (int i = 0; i < int'(out_count); i++) rcv.push_back(d[i*W +: W]);
        end
        fire = m_pend && !exp_pop && (m_acc.size() > 0) && free;
        if (flush && ((m_acc.size() > 0) || exp_pop)) m_pend = 1'b1;
        if (m_valid && out_ready) m_valid = 1'b0;
        if (exp_pop) begin
            m_acc.push_back(fq[0]);
            npops++;
            if (m_acc.size() == R) model_load();
        end else if (fire) begin
            model_load();
        end
        @(posedge clk);
        @(negedge clk);
        if (exp_pop) void'(fq.pop_front());
        flush = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] v);
        fq.push_back(v);
        sent.push_back(v);
    endtask

    initial begin
        int  guard;
        bit  idle;
        rst            = 1'b1;
        flush          = 1'b0;
        out_ready      = 1'b0;
        fifo_empty     = 1'b1;
        fifo_read_data = '0;
        model_reset();
        npops = 0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_count", 64'(out_count), 64'd0);
        rst = 1'b0;

        // Full-rate streaming of 01..08.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(W'(i));
        npops = 0;
        repeat (4) step();
        check_eq("t1_w0", 64'(out_data), 64'h04030201);
        check_eq("t1_c0", 64'(out_count), 64'd4);
        repeat (4) step();
        check_eq("t1_pops", 64'(npops), 64'd8);
        check_eq("t1_w1", 64'(out_data), 64'h08070605);
        repeat (2) step();

        // Partial word via flush, held under back-pressure.
        out_ready = 1'b0;
        push(8'hA0); push(8'hA1); push(8'hA2);
        repeat (3) step();
        flush = 1'b1;
        step();
        step();
        check_eq("t2_valid", 64'(out_valid), 64'd1);
        check_eq("t2_data", 64'(out_data), 64'h00A2A1A0);
        check_eq("t2_count", 64'(out_count), 64'd3);
        repeat (3) step();
        check_eq("t2_hold", 64'(out_data), 64'h00A2A1A0);
        out_ready = 1'b1;
        repeat (2) step();
        check_eq("t2_drained", 64'(out_valid), 64'd0);

        // Flush with nothing accumulated is dropped.
        flush = 1'b1;
        repeat (4) step();
        check_eq("t3_valid", 64'(out_valid), 64'd0);

        // Flush in the same cycle as the pop of the second item.
        push(8'hB0);
        step();
        push(8'hB1);
        flush = 1'b1;
        step();
        step();
        check_eq("t4_data", 64'(out_data), 64'h0000B1B0);
        check_eq("t4_count", 64'(out_count), 64'd2);
        repeat (2) step();

        // Back-pressure with 12 items queued.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push(8'hC0 + W'(i));
        npops = 0;
        repeat (10) step();
        check_eq("t5_pops", 64'(npops), 64'd7);
        check_eq("t5_left", 64'(fq.size()), 64'd5);
        words.delete();
        out_ready = 1'b1;
        repeat (12) step();
        check_eq("t5_nwords", 64'(words.size()), 64'd3);
        if (words.size() >= 2) begin
            check_eq("t5_w1", 64'(words[0]), 64'hC3C2C1C0);
            check_eq("t5_w2", 64'(words[1]), 64'hC7C6C5C4);
        end

        // Asynchronous reset with a word pending and two items accumulated.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hD0 + W'(i));
        repeat (6) step();
        check_eq("t6_pre_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 64'(out_valid), 64'd0);
        check_eq("t6_rst_count", 64'(out_count), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        push(8'hF0); push(8'hF1); push(8'hF2); push(8'hF3);
        repeat (4) step();
        check_eq("t6_fresh", 64'(out_data), 64'hF3F2F1F0);
        check_eq("t6_count", 64'(out_count), 64'd4);
        repeat (2) step();

        // Random traffic with end-to-end item accounting.
        sent.delete();
        rcv.delete();
        for (int c = 0; c < 2000; c++) begin
            if (fq.size() < 16 && $urandom_range(0, 99) < 50) push(W'($urandom));
            if (fq.size() < 16 && $urandom_range(0, 99) < 15) push(W'($urandom));
            flush     = ($urandom_range(0, 99) < 8);
            out_ready = ($urandom_range(0, 99) < 60);
            step();
        end
        out_ready = 1'b1;
        idle  = 1'b0;
        guard = 0;
        while (!idle && guard < 200) begin
            if (fq.size() == 0 && m_acc.size() == 0 && !m_valid) begin
                idle = 1'b1;
            end else begin
                if (fq.size() == 0 && m_acc.size() > 0 && !m_pend) flush = 1'b1;
                step();
                guard++;
            end
        end
        check_eq("rand_drain_idle", 64'(idle), 64'd1);
        check_eq("rand_items", 64'(rcv.size()), 64'(sent.size()));
        for (int i = 0; i < sent.size() && i < rcv.size(); i++) begin
            check_eq("rand_item", 64'(rcv[i]), 64'(sent[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_drain_packer.md
Name: fifo_drain_packer

Overview:
- Downstream consumer of the show-ahead FIFO (push/pop/empty/full, combinational read_data at the head).
- Pops narrow words from the FIFO and packs `ratio` of them into one wide word. The wide word is presented on a valid/ready output register.
- A flush request emits a partially filled word together with its item count, so packet tails are not stranded in the packer.

Parameters:
- width, 8, FIFO item width in bits.
- ratio, 4, items packed per output word. Legal range is ratio >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_data  input  width  FIFO head item. Valid whenever fifo_empty == 0.
- fifo_pop  output  1  FIFO pop strobe. Combinational.
- flush  input  1  single-cycle request to emit the current partial word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  width*ratio  packed word. Item 0 occupies bits [width-1:0].
- out_count  output  $clog2(ratio+1)  number of valid items in out_data, range 1..ratio.

Behaviour:
- Reset: all state clears asynchronously.
  - out_valid=0, out_data=0, out_count=0.
  - Accumulator count=0, accumulator data=0, flush_pending=0.
  - Any partial data is discarded on reset mid-operation.
- State:
  - acc_cnt, range 0..ratio-1.
  - acc_data, width*ratio bits.
  - flush_pending, 1 bit.
  - Output register: out_valid/out_data/out_count.
- Output slot free: out_free = !out_valid | out_ready. A slot being drained this cycle counts as free.
- Pop rule: fifo_pop = !fifo_empty & (acc_cnt < ratio-1 | out_free).
  - fifo_pop is never 1 while fifo_empty=1.
  - There is a combinational path from out_ready to fifo_pop. This path is allowed.
- On a pop, the head item is written into slice acc_cnt of the word.
  - If acc_cnt == ratio-1:
    - Load the output register with the completed word, with out_count=ratio.
    - Set out_valid=1, acc_cnt=0, acc_data=0.
  - Otherwise: acc_cnt+1.
- Flush:
  - flush=1 sets flush_pending, unless acc_cnt==0 with no pop this cycle; in that case the flush is dropped with no output.
  - Flush fires in any cycle with flush_pending=1, no pop, acc_cnt>0 and out_free. When it fires:
    - Load the output register with acc_data and out_count=acc_cnt.
    - Clear the accumulator and clear flush_pending.
  - Pops have priority over the flush transfer.
    - A pop in the same cycle as flush is included in the partial word.
    - The flush fires on the first later cycle with no pop.
  - If a pop completes a full word while flush_pending=1, flush_pending clears and no extra partial word is produced.
  - Unused slices of a partial word are 0.
- Output handshake:
  - out_valid stays 1 and out_data/out_count stay stable until the cycle with out_valid & out_ready.
  - After that cycle, out_valid=0 unless a new word is loaded in the same cycle.
- Throughput and latency:
  - With a non-empty FIFO and out_ready held at 1, one pop per cycle and one word per `ratio` cycles, with no bubbles.
  - The word appears on the output the cycle after the pop of its last item.
- Back-pressure:
  - With out_valid=1 and out_ready=0, the packer pops until acc_cnt=ratio-1, then stalls with fifo_pop=0.
  - No item is lost or duplicated.

Test Plan:
- Reset, then FIFO holds 8'h01..8'h08 and out_ready=1. Expect pops on 8 consecutive cycles. Expect out_data=32'h04030201 with out_count=4, then 32'h08070605 four cycles later.
- Load 8'hA0, 8'hA1, 8'hA2 and hold out_ready=0 until the FIFO is empty. Then pulse flush. Expect out_valid=1 with out_data=32'h00A2A1A0 and out_count=3; the word holds until out_ready=1.
- Pulse flush with the accumulator empty and the FIFO empty. Expect out_valid to stay 0 and no state change.
- Flush asserted in the same cycle as the pop of the 2nd item 8'hB1 (after 8'hB0), with the FIFO empty afterwards. Expect the next cycle out_data=32'h0000B1B0 and out_count=2.
- out_ready=0 with 12 items queued. Expect exactly 7 pops: 4 fill the output register and 3 sit in the accumulator, then fifo_pop=0. Raise out_ready and expect words 1 and 2 in order with no loss.
- Assert rst with acc_cnt=2 and out_valid=1. Expect out_valid=0 and out_count=0 immediately. After release, the next word starts fresh from the FIFO head.
